// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding for the bit-serial subtractor
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_fs_cell.sv
// serial_fs_cell: combinational full subtractor (a - b - bin)
module serial_fs_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial A - B behind a start/ready/done handshake
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             ovf_o
);
    localparam int CW = $clog2(WIDTH);
    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;
    serial_fs_cell u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );
    assign ready_o  = r_state != RUN;
    assign w_accept = ready_o && start_i;
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    // on the last bit the shift registers' LSBs hold the original operand MSBs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            diff_o    <= '0;
            borrow_o  <= 1'b0;
            ovf_o     <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (w_accept) begin
                r_state   <= RUN;
                r_a_sr    <= a_i;
                r_b_sr    <= b_i;
                r_diff_sr <= '0;
                r_cnt     <= '0;
                r_borrow  <= 1'b0;
            end else if (r_state == RUN) begin
                r_a_sr    <= r_a_sr >> 1;
                r_b_sr    <= r_b_sr >> 1;
                r_diff_sr <= {w_d, r_diff_sr[WIDTH-1:1]};
                r_borrow  <= w_bout;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    r_state  <= DONE;
                    diff_o   <= {w_d, r_diff_sr[WIDTH-1:1]};
                    borrow_o <= w_bout;
                    ovf_o    <= (r_a_sr[0] ^ r_b_sr[0]) & (w_d ^ r_a_sr[0]);
                    done_o   <= 1'b1;
                end
            end else begin
                r_state <= IDLE;
            end
        end
    end
endmodule
